// File: rtl/perm_pkg.sv
// perm_pkg: shared widths, round constants, rotation amounts and FSM states for the ASCON permutation
package perm_pkg;

    localparam int STATE_W    = 320;
    localparam int LANE_W     = 64;
    localparam int MAX_ROUNDS = 12;

    localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_state_e;

    function automatic logic [7:0] rc(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    function automatic logic [LANE_W-1:0] ror(input logic [LANE_W-1:0] v, input int unsigned n);
        return (v >> n) | (v << (LANE_W - n));
    endfunction

endpackage

// File: rtl/perm_round.sv
// perm_round: one combinational ASCON round (constant, bitsliced S-box, linear layer)
module perm_round
    import perm_pkg::*;
(
    input  logic [STATE_W-1:0] state_in,
    input  logic [3:0]         r,
    output logic [STATE_W-1:0] state_out
);

    // full round on five 64-bit lanes, x0 in the top bits
    always_comb begin
        logic [LANE_W-1:0] x [5];
        logic [LANE_W-1:0] t [5];
        {x[0], x[1], x[2], x[3], x[4]} = state_in;
        x[2] = x[2] ^ {56'b0, rc(r)};
        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
        for (int i = 0; i < 5; i++) x[i] = x[i] ^ t[(i + 1) % 5];
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];
        for (int i = 0; i < 5; i++) x[i] = x[i] ^ ror(x[i], ROT_A[i]) ^ ror(x[i], ROT_B[i]);
        state_out = {x[0], x[1], x[2], x[3], x[4]};
    end

endmodule

// File: rtl/perm_round_core.sv
// perm_round_core: runs nr ASCON rounds one per cycle and hands handshakes to the round counter
module perm_round_core
    import perm_pkg::*;
#(
    parameter int MAX_ROUNDS = perm_pkg::MAX_ROUNDS,
    parameter int CTR_W      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [3:0]         rounds_i,
    input  logic [STATE_W-1:0] state_i,
    input  logic [CTR_W-1:0]   round_ctr_i,
    output logic               perm_start_o,
    output logic               perm_ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [STATE_W-1:0] state_o,
    output logic               err_o
);

    perm_state_e        st_q, st_d;
    logic [STATE_W-1:0] state_q, round_out;
    logic [3:0]         nr_q, rnd_q, nr_d, r;
    logic               go, run, last;

    assign go     = (st_q == IDLE) && start_i;
    assign run    = (st_q == RUN);
    assign last   = run && (rnd_q == nr_q - 4'd1);
    assign nr_d   = (rounds_i == 4'd0 || rounds_i > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : rounds_i;
    assign r      = 4'(MAX_ROUNDS) - nr_q + rnd_q;
    assign busy_o = (st_q != IDLE);

    perm_round u_round (
        .state_in  (state_q),
        .r         (r),
        .state_out (round_out)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) st_q <= IDLE;
        else     st_q <= st_d;
    end

    // next state: IDLE -> RUN on start, RUN -> DONE after the last round, DONE -> IDLE
    always_comb begin
        st_d = go ? RUN : last ? DONE : (st_q == DONE) ? IDLE : st_q;
    end

    // datapath, round bookkeeping, counter handshakes and sticky counter check
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= '0;
            nr_q         <= 4'(MAX_ROUNDS);
            rnd_q        <= '0;
            perm_start_o <= 1'b0;
            perm_ready_o <= 1'b0;
            done_o       <= 1'b0;
            state_o      <= '0;
            err_o        <= 1'b0;
        end else begin
            done_o       <= 1'b0;
            perm_ready_o <= 1'b0;
            if (go) begin
                state_q      <= state_i;
                nr_q         <= nr_d;
                rnd_q        <= '0;
                perm_start_o <= 1'b1;
            end
            if (run) begin
                state_q <= round_out;
                rnd_q   <= rnd_q + 4'd1;
                err_o   <= err_o | (round_ctr_i != CTR_W'(rnd_q));
            end
            if (last) begin
                perm_start_o <= 1'b0;
                perm_ready_o <= 1'b1;
                done_o       <= 1'b1;
                state_o      <= round_out;
            end
        end
    end

endmodule

// File: tb/tb_perm_round_core.sv
// tb_perm_round_core: directed checks of perm_round_core against a lane-level ASCON reference
module tb_perm_round_core;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [3:0]   rounds_i = 4'd12;
    logic [319:0] state_i = '0;
    logic [4:0]   round_ctr_i;
    logic         perm_start_o, perm_ready_o, busy_o, done_o, err_o;
    logic [319:0] state_o;

    logic [4:0]   ctr = '0;
    logic         force_ctr = 1'b0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    // stand-in for RoundCounter: counts while permutation_start is high, else reads 0
    always @(posedge clk) ctr <= (rst || !perm_start_o) ? 5'd0 : ctr + 5'd1;
    assign round_ctr_i = force_ctr ? 5'd3 : ctr;

    perm_round_core dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .rounds_i     (rounds_i),
        .state_i      (state_i),
        .round_ctr_i  (round_ctr_i),
        .perm_start_o (perm_start_o),
        .perm_ready_o (perm_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .state_o      (state_o),
        .err_o        (err_o)
    );

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 ^= 64'((15 - r) * 16 + r);
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
        x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
        x2 ^= rotr(x2, 1) ^ rotr(x2, 6);
        x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
        x4 ^= rotr(x4, 7) ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
        logic [319:0] v = s;
        for (int r = 12 - nr; r < 12; r++) v = ref_round(v, r);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " done"}, done_o, 0);
        chk({tag, " ready"}, perm_ready_o, 0);
        chk({tag, " pstart"}, perm_start_o, 0);
        chk({tag, " busy"}, busy_o, 0);
    endtask

    // start in the current cycle, walk nr RUN cycles, check the DONE cycle and return to IDLE
    task automatic run_perm(input string tag, input logic [3:0] rn, input logic [319:0] s, input int nr);
        start_i  = 1'b1;
        rounds_i = rn;
        state_i  = s;
        step();
        start_i = 1'b0;
        state_i = '1;
        for (int k = 1; k <= nr; k++) begin
            chk({tag, " run pstart"}, perm_start_o, 1);
            chk({tag, " run done"}, done_o, 0);
            chk({tag, " run busy"}, busy_o, 1);
            step();
        end
        chk({tag, " done"}, done_o, 1);
        chk({tag, " ready"}, perm_ready_o, 1);
        chk({tag, " pstart low"}, perm_start_o, 0);
        chk({tag, " state"}, state_o, ref_perm(s, nr));
        chk({tag, " err"}, err_o, 0);
        step();
        chk_idle({tag, " after"});
        chk({tag, " held"}, state_o, ref_perm(s, nr));
    endtask

    logic [319:0] s1, s2;

    initial begin
        s1 = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h00000000000000ff,
              64'h8000000000000001, 64'hdeadbeefcafef00d};
        s2 = {64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
              64'h4444444444444444, 64'h5555555555555555};

        step();
        step();
        chk_idle("reset");
        chk("reset state_o", state_o, 0);
        chk("reset err", err_o, 0);
        rst = 1'b0;
        step();
        chk_idle("post reset");

        run_perm("p12 zero", 4'd12, '0, 12);
        run_perm("p6", 4'd6, s1, 6);
        run_perm("p1", 4'd1, s2, 1);
        run_perm("nr0", 4'd0, s1, 12);
        run_perm("nr15", 4'd15, s1, 12);

        start_i  = 1'b1;
        rounds_i = 4'd12;
        state_i  = s1;
        step();
        state_i  = s2;
        rounds_i = 4'd3;
        for (int k = 1; k <= 12; k++) step();
        chk("hold done", done_o, 1);
        chk("hold state", state_o, ref_perm(s1, 12));
        step();
        chk("hold idle busy", busy_o, 0);
        rounds_i = 4'd12;
        step();
        start_i = 1'b0;
        chk("hold restart busy", busy_o, 1);
        chk("hold first kept", state_o, ref_perm(s1, 12));
        for (int k = 1; k <= 12; k++) step();
        chk("hold second done", done_o, 1);
        chk("hold second state", state_o, ref_perm(s2, 12));
        step();

        start_i  = 1'b1;
        rounds_i = 4'd12;
        state_i  = s2;
        step();
        start_i = 1'b0;
        step();
        step();
        force_ctr = 1'b1;
        chk("err before", err_o, 0);
        step();
        force_ctr = 1'b0;
        chk("err rise", err_o, 1);
        for (int k = 4; k <= 12; k++) step();
        chk("err done", done_o, 1);
        chk("err state", state_o, ref_perm(s2, 12));
        chk("err sticky", err_o, 1);
        step();
        chk("err sticky idle", err_o, 1);

        start_i  = 1'b1;
        rounds_i = 4'd12;
        state_i  = s1;
        step();
        start_i = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("mid rst");
        chk("mid rst state_o", state_o, 0);
        chk("mid rst err", err_o, 0);
        step();
        chk_idle("mid rst hold");
        run_perm("after rst", 4'd12, s1, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/perm_round_core.md
Name: perm_round_core

Overview:
- Round datapath and control for the ASCON permutation used by the hash/XOF path.
- Sits directly downstream of RoundCounter: drives its permutation_start and permutation_ready inputs, and consumes its 5-bit counter as the round index.
- Loads a 320-bit state, applies one round per cycle for a runtime-selected number of rounds, then returns the permuted state with a done pulse.

Parameters:
- MAX_ROUNDS, 12, number of rounds in the full permutation; sets the round-constant offset.
- CTR_W, 5, width of the round counter input.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  load state_i and begin the permutation; sampled only in IDLE
- rounds_i  input  4  rounds to apply, 1..12; sampled with start_i
- state_i  input  320  input state; x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0]
- round_ctr_i  input  CTR_W  RoundCounter counter output
- perm_start_o  output  1  to RoundCounter permutation_start
- perm_ready_o  output  1  to RoundCounter permutation_ready
- busy_o  output  1  high in RUN and DONE
- done_o  output  1  one-cycle pulse; state_o valid
- state_o  output  320  permuted state, held until the next start
- err_o  output  1  sticky; counter/expected-round mismatch

Behaviour:
- Reset values: state register 0, FSM IDLE, nr_q=12, rnd_q=0. All outputs 0, including state_o.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE + start_i (cycle t):
  - state_reg <= state_i.
  - nr_q <= rounds_i; 0 or >12 is clamped to 12.
  - rnd_q <= 0; perm_start_o <= 1; go to RUN.
- RUN (cycles t+1 .. t+nr):
  - Apply one round per cycle, using round index r = (MAX_ROUNDS - nr_q) + rnd_q.
  - rnd_q increments each cycle.
  - When rnd_q == nr_q-1: perm_start_o <= 0, perm_ready_o <= 1, go to DONE.
- DONE (cycle t+nr+1):
  - done_o = 1 and state_o = state_reg, both registered.
  - perm_ready_o is high this cycle only, then clears; go to IDLE.
- Latency: start to done_o = nr+1 cycles (13 for 12 rounds). The next start is accepted the cycle after done_o.
- start_i in RUN or DONE is ignored.
- Counter check: every RUN cycle, round_ctr_i must equal rnd_q. A mismatch sets err_o, which stays set until rst; the datapath always uses the internal rnd_q. RoundCounter reads 0 on the first RUN cycle because perm_start_o was low in the previous cycle.
- Round function (64-bit lanes):
  - Constant: x2 ^= {56'b0, (4'hF - r[3:0]), r[3:0]}.
  - S-box, bitsliced:
    - x0^=x4; x4^=x3; x2^=x1.
    - t_i = ~x_i & x_(i+1 mod 5); x_i ^= t_(i+1 mod 5).
    - x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer, right rotations:
    - x0^=ror19^ror28
    - x1^=ror61^ror39
    - x2^=ror1^ror6
    - x3^=ror10^ror17
    - x4^=ror7^ror41
  - Single-cycle combinational round; no pipelining.
- rst mid-operation: next cycle is IDLE with all outputs 0. The partial state is discarded and err_o is cleared.

Decomposition:
- Shared package perm_pkg:
  - state width 320, lane width 64.
  - MAX_ROUNDS.
  - rotation amount constants.
  - FSM state enum (IDLE, RUN, DONE).
  - function rc(r) returning the 8-bit round constant.
- Sub-module perm_round: purely combinational, state_in[319:0] + r[3:0] -> state_out[319:0].
- perm_round_core instantiates perm_round and the FSM. The bench instantiates RoundCounter alongside it.

Test Plan:
- Reset, then start_i with state_i=0, rounds_i=12:
  - perm_start_o high for cycles t+1..t+12.
  - perm_ready_o and done_o at t+13.
  - state_o matches the golden model's p12(0); err_o stays 0.
- rounds_i=6: the first round uses constant 0x96 and the last uses 0x4B. done_o arrives at t+7 and state_o matches the golden model's p6.
- rounds_i=0 and rounds_i=15: both behave exactly like 12 (done at t+13, same state_o as p12).
- start_i held high through RUN/DONE: ignored. A second permutation starts only when start_i is seen in IDLE, and the first result is unchanged.
- Force round_ctr_i to 3 during the rnd_q=2 cycle: err_o rises the next cycle and stays high. state_o still matches the golden result.
- Assert rst at t+5 of a 12-round run: all outputs 0 the next cycle. A new start afterwards gives the correct p12 with done at +13.
